lcd_frame_streamer: RTL and testbench

//  Upstream feeder of the LT24 pixel driver. On start, it scans the 160x144 LCD drawing window
//  in row-major order (x fastest) and emits one RGB565 pixel per slot on pixel_rgb/print.
//  - Inside a centred area, each pixel is an 8-bit grayscale sample of the 28x28 digit

---
 rtl/lcd_frame_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_frame_streamer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: scans the LCD window row-major and feeds one RGB565 pixel per slot to the LT24 driver.
// Latency: one pixel slot = PIX_CYCLES+2 clocks (FETCH, WAIT, SEND x PIX_CYCLES); framebuffer read takes 1 clk.
// Backpressure: none; print is a fixed 2-clk request, abort or loss of lcd_initialized returns to IDLE next clk.
module lcd_frame_streamer #(
    parameter int          SRC_W      = 28,
    parameter int          SRC_H      = 28,
    parameter int          SCALE      = 5,
    parameter int          WIN_W      = 160,
    parameter int          WIN_H      = 144,
    parameter int          X_OFF      = 10,
    parameter int          Y_OFF      = 2,
    parameter int          PIX_CYCLES = 4,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        lcd_initialized,
    output logic        fb_rd,
    output logic [9:0]  fb_addr,
    input  logic [7:0]  fb_data,
    output logic [15:0] pixel_rgb,
    output logic        print,
    output logic        lcd_en,
    output logic        busy,
    output logic        frame_done
);
    localparam int XW  = $clog2(WIN_W + 1);
    localparam int YW  = $clog2(WIN_H + 1);
    localparam int SXW = $clog2(SRC_W + 1);
    localparam int SYW = $clog2(SRC_H + 1);
    localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int PCW = $clog2(PIX_CYCLES);
    localparam int AW  = 10;

    localparam logic [XW-1:0]  X_LAST  = XW'(WIN_W - 1);
    localparam logic [XW-1:0]  X_BEG   = XW'(X_OFF);
    localparam logic [XW-1:0]  X_END   = XW'(X_OFF + SRC_W * SCALE);
    localparam logic [YW-1:0]  Y_LAST  = YW'(WIN_H - 1);
    localparam logic [YW-1:0]  Y_BEG   = YW'(Y_OFF);
    localparam logic [YW-1:0]  Y_END   = YW'(Y_OFF + SRC_H * SCALE);
    localparam logic [SW-1:0]  S_LAST  = SW'(SCALE - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PIX_CYCLES - 1);
    localparam logic           X_IN0   = (X_OFF == 0);
    localparam logic           Y_IN0   = (Y_OFF == 0);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            in_x, in_y;          // current window position lies in image columns / rows
    logic [SXW-1:0]  sx;
    logic [SYW-1:0]  sy;
    logic [SW-1:0]   sub_x, sub_y;
    logic [AW-1:0]   row_base;            // sy*SRC_W, grown by SRC_W per source row
    logic [PCW-1:0]  pc;

    logic [XW-1:0]   x_nx;
    logic [YW-1:0]   y_nx;
    logic            in_x_nx, in_y_nx;
    logic [SXW-1:0]  sx_nx;
    logic [SYW-1:0]  sy_nx;
    logic [SW-1:0]   sub_x_nx, sub_y_nx;
    logic [AW-1:0]   row_base_nx;
    logic [AW-1:0]   addr_nx;
    logic            last_pix;

    // The two low grey bits never reach RGB565.
    logic unused_gray_lsbs;
    assign unused_gray_lsbs = ^fb_data[1:0];

    // Position of the following pixel, derived incrementally from the current one.
    always_comb begin
        x_nx        = x + XW'(1);
        y_nx        = y;
        in_x_nx     = in_x;
        in_y_nx     = in_y;
        sx_nx       = sx;
        sub_x_nx    = sub_x;
        sy_nx       = sy;
        sub_y_nx    = sub_y;
        row_base_nx = row_base;
        last_pix    = (x == X_LAST) && (y == Y_LAST);

        if (in_x) begin
            if (sub_x == S_LAST) begin
                sub_x_nx = '0;
                sx_nx    = sx + SXW'(1);
            end else begin
                sub_x_nx = sub_x + SW'(1);
            end
        end
        if (x_nx == X_BEG)
            in_x_nx = 1'b1;
        else if (x_nx == X_END)
            in_x_nx = 1'b0;

        if (x == X_LAST) begin
            x_nx     = '0;
            in_x_nx  = X_IN0;
            sx_nx    = '0;
            sub_x_nx = '0;
            y_nx     = y + YW'(1);
            if (in_y) begin
                if (sub_y == S_LAST) begin
                    sub_y_nx    = '0;
                    sy_nx       = sy + SYW'(1);
                    row_base_nx = row_base + AW'(SRC_W);
                end else begin
                    sub_y_nx = sub_y + SW'(1);
                end
            end
            if (y_nx == Y_BEG)
                in_y_nx = 1'b1;
            else if (y_nx == Y_END)
                in_y_nx = 1'b0;
        end

        addr_nx = row_base_nx + AW'(sx_nx);
    end

    // Frame FSM with registered driver-facing outputs; read strobe/address are set on entry to FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            in_x       <= 1'b0;
            in_y       <= 1'b0;
            sx         <= '0;
            sy         <= '0;
            sub_x      <= '0;
            sub_y      <= '0;
            row_base   <= '0;
            pc         <= '0;
            fb_rd      <= 1'b0;
            fb_addr    <= '0;
            pixel_rgb  <= '0;
            print      <= 1'b0;
            lcd_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && (abort || !lcd_initialized)) begin
                state  <= IDLE;
                print  <= 1'b0;
                fb_rd  <= 1'b0;
                busy   <= 1'b0;
                lcd_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && lcd_initialized && !abort) begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            lcd_en   <= 1'b1;
                            x        <= '0;
                            y        <= '0;
                            in_x     <= X_IN0;
                            in_y     <= Y_IN0;
                            sx       <= '0;
                            sy       <= '0;
                            sub_x    <= '0;
                            sub_y    <= '0;
                            row_base <= '0;
                            fb_addr  <= '0;
                            fb_rd    <= X_IN0 && Y_IN0;
                        end
                    end
                    FETCH: begin
                        fb_rd <= 1'b0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        pixel_rgb <= (in_x && in_y) ? {fb_data[7:3], fb_data[7:2], fb_data[7:3]}
                                                    : BG_COLOR;
                        print     <= 1'b1;
                        pc        <= '0;
                        state     <= SEND;
                    end
                    SEND: begin
                        print <= (pc == '0);
                        pc    <= pc + PCW'(1);
                        if (pc == PC_LAST) begin
                            print <= 1'b0;
                            if (last_pix) begin
                                state      <= IDLE;
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                lcd_en     <= 1'b0;
                            end else begin
                                x        <= x_nx;
                                y        <= y_nx;
                                in_x     <= in_x_nx;
                                in_y     <= in_y_nx;
                                sx       <= sx_nx;
                                sy       <= sy_nx;
                                sub_x    <= sub_x_nx;
                                sub_y    <= sub_y_nx;
                                row_base <= row_base_nx;
                                fb_addr  <= addr_nx;
                                fb_rd    <= in_x_nx && in_y_nx;
                                state    <= FETCH;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer on a reduced geometry (20x12 window, 4x3 source, x3 scale).
// Image area: x 5..16, y 1..9; slot index of window pixel (x,y) is y*20+x; 240 slots of 6 clocks.
// Background colour is non-zero so that background and black pixels are distinguishable.
module tb_lcd_frame_streamer;
    localparam int          SRC_W      = 4;
    localparam int          SRC_H      = 3;
    localparam int          SCALE      = 3;
    localparam int          WIN_W      = 20;
    localparam int          WIN_H      = 12;
    localparam int          X_OFF      = 5;
    localparam int          Y_OFF      = 1;
    localparam int          PIX_CYCLES = 4;
    localparam logic [15:0] BG         = 16'h001F;
    localparam int          SLOTS      = WIN_W * WIN_H;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lcd_initialized = 1'b0;
    logic        fb_rd;
    logic [9:0]  fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic [15:0] pixel_rgb;
    logic        print;
    logic        lcd_en;
    logic        busy;
    logic        frame_done;

    logic [7:0]  mem [0:1023];
    logic [15:0] cap [0:SLOTS-1];

    int   n_assert = 0;
    int   n_fail = 0;
    logic mon_clr = 1'b0;
    int   pairs = 0;
    int   print_cycles = 0;
    int   reads = 0;
    int   dones = 0;
    int   done_pairs = 0;
    logic prev_print = 1'b0;

    always #5 clk = ~clk;

    lcd_frame_streamer #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .WIN_W(WIN_W), .WIN_H(WIN_H),
        .X_OFF(X_OFF), .Y_OFF(Y_OFF), .PIX_CYCLES(PIX_CYCLES), .BG_COLOR(BG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .lcd_initialized(lcd_initialized),
        .fb_rd(fb_rd),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .pixel_rgb(pixel_rgb),
        .print(print),
        .lcd_en(lcd_en),
        .busy(busy),
        .frame_done(frame_done)
    );

    // Synchronous framebuffer: data valid the clock after the read strobe.
    always @(posedge clk) begin
        if (fb_rd) fb_data <= mem[fb_addr];
    end

    // Driver-side observer, sampling 1 time unit after each falling edge.
    always begin
        @(negedge clk);
        #1;
        if (mon_clr) begin
            pairs        = 0;
            print_cycles = 0;
            reads        = 0;
            dones        = 0;
            done_pairs   = 0;
            prev_print   = 1'b0;
        end else begin
            if (print) begin
                print_cycles++;
                if (!prev_print) begin
                    if (pairs < SLOTS) cap[pairs] = pixel_rgb;
                    pairs++;
                end
            end
            if (fb_rd) reads++;
            if (frame_done) begin
                dones++;
                done_pairs = pairs;
            end
            prev_print = print;
        end
    end

    function automatic logic [15:0] rgb(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        @(negedge clk);
    endtask

    // Pulse start and follow the frame; span counts the start cycle plus every busy cycle.
    // A second start is injected mid-frame when restart_at is non-zero.
    task automatic run_frame(input int restart_at, output int span);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        span = 1;
        while (busy === 1'b1 && span < 5000) begin
            start = (restart_at != 0) && (span == restart_at);
            span++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++)
            mem[i] = (i < SRC_W * SRC_H) ? 8'(i * 20 + 24) : 8'h00;

        // Reset state
        #12;
        chk("reset_outputs", {1'b0, fb_rd, fb_addr, pixel_rgb, print, lcd_en, busy, frame_done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Start without lcd_initialized is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_without_init", {busy, lcd_en}, 32'h0);

        // Start and abort together: abort wins
        lcd_initialized = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_with_abort", {busy, lcd_en}, 32'h0);

        // Asynchronous reset in the middle of a frame
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_reset_busy", {busy, lcd_en}, 32'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {1'b0, fb_rd, fb_addr, pixel_rgb, print, lcd_en, busy, frame_done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_after_reset", {busy, print, frame_done}, 32'h0);

        // Full frame, with an ignored start pulse in the middle
        clear_monitor();
        run_frame(300, n);
        chk("frame_span_cycles", n, SLOTS * 6 + 1);
        chk("frame_done_at_end", frame_done, 1'b1);
        @(negedge clk);
        chk("frame_done_one_clk", frame_done, 1'b0);
        repeat (4) @(negedge clk);
        chk("frame_print_pairs", pairs, SLOTS);
        chk("frame_print_cycles", print_cycles, 2 * SLOTS);
        chk("frame_fb_reads", reads, SRC_W * SRC_H * SCALE * SCALE);
        chk("frame_done_count", dones, 1);
        chk("frame_done_slot", done_pairs, SLOTS);
        chk("no_restart", busy, 1'b0);

        // Pixel mapping
        chk("pix_0_0_bg",      cap[0],   BG);
        chk("pix_5_1_fb0",     cap[25],  rgb(mem[0]));
        chk("pix_7_1_fb0",     cap[27],  rgb(mem[0]));
        chk("pix_8_1_fb1",     cap[28],  rgb(mem[1]));
        chk("pix_5_4_fb4",     cap[85],  rgb(mem[4]));
        chk("pix_10_6_fb5",    cap[130], rgb(mem[5]));
        chk("pix_16_9_fb11",   cap[196], rgb(mem[11]));
        chk("pix_17_1_bg",     cap[37],  BG);
        chk("pix_4_5_bg",      cap[104], BG);
        chk("pix_5_10_bg",     cap[205], BG);
        chk("pix_5_1_literal", cap[25],  16'h18C3);

        // Abort at slot 50
        clear_monitor();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (pairs < 50 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_slot_reached", pairs, 50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_next_clk", {busy, lcd_en, print, fb_rd}, 32'h0);
        repeat (20) @(negedge clk);
        chk("abort_no_frame_done", dones, 0);
        chk("abort_no_more_pixels", pairs, 50);

        // Loss of lcd_initialized mid-frame
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        lcd_initialized = 1'b0;
        @(negedge clk);
        chk("init_loss_idle", {busy, lcd_en, print}, 32'h0);
        lcd_initialized = 1'b1;
        repeat (3) @(negedge clk);

        // New frame after abort, with colour extremes in the framebuffer
        mem[0] = 8'hFF;
        mem[1] = 8'h80;
        mem[2] = 8'h00;
        clear_monitor();
        run_frame(0, n);
        repeat (4) @(negedge clk);
        chk("refresh_span_cycles", n, SLOTS * 6 + 1);
        chk("refresh_print_pairs", pairs, SLOTS);
        chk("refresh_done_slot", done_pairs, SLOTS);
        chk("refresh_first_pixel", cap[0], BG);
        chk("colour_ff", cap[25], 16'hFFFF);
        chk("colour_80", cap[28], 16'h8410);
        chk("colour_00", cap[31], 16'h0000);
        chk("refresh_last_pixel", cap[SLOTS-1], BG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
